// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the internal 8-bit strobe/ack slave bus.
// Optional transaction timeout is built only when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       m0_stb_i,
    input  logic       m0_we_i,
    input  logic [7:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    output logic [7:0] m0_dat_o,
    output logic       m0_ack_o,
    output logic       m0_err_o,
    input  logic       m1_stb_i,
    input  logic       m1_we_i,
    input  logic [7:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    output logic [7:0] m1_dat_o,
    output logic       m1_ack_o,
    output logic       m1_err_o,
    output logic       s_stb_o,
    output logic       s_we_o,
    output logic [7:0] s_adr_o,
    output logic [7:0] s_dat_o,
    input  logic [7:0] s_dat_i,
    input  logic       s_ack_i,
    output logic [1:0] gnt_o
);

    // Handshake: a master holds stb (and we/adr/dat stable) until it sees ack or err;
    // a transfer completes in the cycle where the granted stb and s_ack_i are both high.

    // Encodings double as the one-hot grant, so gnt_o is the visible FSM state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   tmo_hit;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES out of range 2..255");
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == IDLE) begin
            cnt_q <= 8'd0;
        end else if (!s_ack_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Ack in the same cycle wins over the timeout.
    assign tmo_hit = (state_q != IDLE) && (cnt_q == 8'(TIMEOUT_CYCLES - 1)) && !s_ack_i;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = 8'h00;
        s_dat_o  = 8'h00;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = 8'h00;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = 8'h00;

        case (state_q)
            IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_stb_i) begin
                    state_d = GNT0;
                end else if (m1_stb_i) begin
                    state_d = GNT1;
                end
            end

            GNT0: begin
                s_stb_o  = m0_stb_i && !tmo_hit;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i && m0_stb_i;
                m0_err_o = tmo_hit && m0_stb_i;
                m0_dat_o = s_dat_i;
                if (s_ack_i && m0_stb_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (!m0_stb_i) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end

            GNT1: begin
                s_stb_o  = m1_stb_i && !tmo_hit;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i && m1_stb_i;
                m1_err_o = tmo_hit && m1_stb_i;
                m1_dat_o = s_dat_i;
                if (s_ack_i && m1_stb_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (!m1_stb_i) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: registered-ack slave model, ack scoreboard
// keyed by {master, read data}, and cycle-exact grant/strobe/err checks.
module tb_bus_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
    logic [7:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [7:0] m0_dat_o, m1_dat_o;
    logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic       s_stb_o, s_we_o;
    logic [7:0] s_adr_o, s_dat_o;
    logic [7:0] s_dat_i;
    logic       s_ack_i;
    logic [1:0] gnt_o;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    logic slave_en = 1'b0;
    logic [8:0] exp_q[$];

    bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, gnt_o, 2'b00);
        check({tag, "_s_stb"}, s_stb_o, 1'b0);
        check({tag, "_s_we"}, s_we_o, 1'b0);
        check({tag, "_s_adr"}, s_adr_o, 8'h00);
        check({tag, "_s_dat"}, s_dat_o, 8'h00);
        check({tag, "_acks"}, {m0_ack_o, m1_ack_o}, 2'b00);
        check({tag, "_errs"}, {m0_err_o, m1_err_o}, 2'b00);
        check({tag, "_m0_dat"}, m0_dat_o, 8'h00);
        check({tag, "_m1_dat"}, m1_dat_o, 8'h00);
    endtask

    task automatic wait_acks(input int target);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i);
            if (ack_cnt >= target) break;
        end
        check("ack_wait", 9'(ack_cnt), 9'(target));
    endtask

    // Registered-ack slave: acks one cycle after it sees a fresh strobe.
    // Reads return 0xA1 to M0 and 0xB2 to M1; writes return 0x00.
    initial begin
        logic       stb_n;
        logic [7:0] dat_n;
        s_ack_i = 1'b0;
        s_dat_i = 8'h00;
        forever begin
            @(negedge clk_i);
            stb_n = s_stb_o && !s_ack_i;
            dat_n = s_we_o ? 8'h00 : ((gnt_o == 2'b01) ? 8'hA1 : 8'hB2);
            @(posedge clk_i);
            #1;
            s_ack_i = slave_en && stb_n && !rst_i;
            s_dat_i = s_ack_i ? dat_n : 8'h00;
        end
    end

    // Scoreboard: every master ack pops one expected {master, data} entry.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk_i);
            if (m0_ack_o || m1_ack_o) begin
                ack_cnt++;
                check("ack_single", {m0_ack_o, m1_ack_o} == 2'b11, 1'b0);
                if (exp_q.size() == 0) begin
                    check("ack_extra", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_data", {m1_ack_o, m1_ack_o ? m1_dat_o : m0_dat_o}, e);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = 8'h00; m0_dat_i = 8'h00;
        m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = 8'h00; m1_dat_i = 8'h00;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_quiet("idle");
        end

        // M0 write, registered-ack slave
        slave_en = 1'b1;
        @(posedge clk_i); #1;
        m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 8'h23; m0_dat_i = 8'h5A;
        m1_adr_i = 8'h77; m1_dat_i = 8'h66; m1_we_i = 1'b0;
        exp_q.push_back({1'b0, 8'h00});
        @(negedge clk_i);
        check("wr_arb_gnt", gnt_o, 2'b00);
        check("wr_arb_stb", s_stb_o, 1'b0);
        @(negedge clk_i);
        check("wr_gnt", gnt_o, 2'b01);
        check("wr_s_stb", s_stb_o, 1'b1);
        check("wr_s_we", s_we_o, 1'b1);
        check("wr_s_adr", s_adr_o, 8'h23);
        check("wr_s_dat", s_dat_o, 8'h5A);
        check("wr_ack_early", m0_ack_o, 1'b0);
        @(negedge clk_i);
        check("wr_ack", m0_ack_o, 1'b1);
        check("wr_m1_quiet", {m1_ack_o, m1_dat_o}, 9'h000);
        @(posedge clk_i); #1;
        m0_stb_i = 1'b0; m0_we_i = 1'b0;
        @(negedge clk_i);
        check_quiet("wr_done");

        // M1 granted, then abandons before any ack; waiting M0 goes next
        slave_en = 1'b0;
        @(posedge clk_i); #1;
        m1_stb_i = 1'b1; m1_adr_i = 8'h40;
        @(negedge clk_i);
        check("ab_arb", gnt_o, 2'b00);
        @(posedge clk_i); #1;
        m0_stb_i = 1'b1; m0_adr_i = 8'h41;
        @(negedge clk_i);
        check("ab_gnt1", gnt_o, 2'b10);
        check("ab_s_stb", s_stb_o, 1'b1);
        check("ab_s_adr", s_adr_o, 8'h40);
        @(posedge clk_i); #1;
        m1_stb_i = 1'b0;
        slave_en = 1'b1;
        exp_q.push_back({1'b0, 8'hA1});
        @(negedge clk_i);
        check("ab_hold_gnt", gnt_o, 2'b10);
        check("ab_stb_low", s_stb_o, 1'b0);
        check("ab_no_ack", m1_ack_o, 1'b0);
        @(negedge clk_i);
        check("ab_idle", gnt_o, 2'b00);
        @(negedge clk_i);
        check("ab_next_m0", gnt_o, 2'b01);
        check("ab_next_adr", s_adr_o, 8'h41);
        wait_acks(2);
        #1 m0_stb_i = 1'b0;

        // M1 solo read leaves last = M1
        m1_stb_i = 1'b1; m1_adr_i = 8'h40;
        exp_q.push_back({1'b1, 8'hB2});
        wait_acks(3);
        #1 m1_stb_i = 1'b0;
        @(negedge clk_i);
        check("solo_done", gnt_o, 2'b00);

        // Both request continuously: grants alternate M0, M1, M0, M1
        @(posedge clk_i); #1;
        m0_stb_i = 1'b1; m0_adr_i = 8'h40;
        m1_stb_i = 1'b1; m1_adr_i = 8'h40;
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b1, 8'hB2});
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b1, 8'hB2});
        @(negedge clk_i);
        @(negedge clk_i);
        check("rr_first", gnt_o, 2'b01);
        wait_acks(7);
        #1 m0_stb_i = 1'b0; m1_stb_i = 1'b0;

        // M0 read leaves last = M0, so only reset can make M0 win the next tie
        m0_stb_i = 1'b1; m0_adr_i = 8'h41;
        exp_q.push_back({1'b0, 8'hA1});
        wait_acks(8);
        #1 m0_stb_i = 1'b0;

        // Reset during a granted read
        slave_en = 1'b0;
        @(posedge clk_i); #1;
        m0_stb_i = 1'b1; m0_adr_i = 8'h42;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_pre_gnt", gnt_o, 2'b01);
        check("rst_pre_stb", s_stb_o, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m1_stb_i = 1'b1; m1_adr_i = 8'h43;
        @(negedge clk_i);
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_stb", s_stb_o, 1'b0);
        check("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'h0);
        @(negedge clk_i);
        check("rst_tie_m0", gnt_o, 2'b01);
        @(posedge clk_i); #1;
        m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_clean", gnt_o, 2'b00);

        // Unanswered M0 request: timeout abort (configured) or indefinite hold
        @(posedge clk_i); #1;
        m0_stb_i = 1'b1; m0_adr_i = 8'h44;
        @(negedge clk_i);
        check("to_arb", gnt_o, 2'b00);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            check("to_wait_gnt", gnt_o, 2'b01);
            check("to_wait_stb", s_stb_o, 1'b1);
            check("to_wait_err", m0_err_o, 1'b0);
        end
        @(negedge clk_i);
        check("to_4th_gnt", gnt_o, 2'b01);
        check("to_m1_err", m1_err_o, 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
        check("to_err", m0_err_o, 1'b1);
        check("to_stb_cut", s_stb_o, 1'b0);
`else
        check("to_err", m0_err_o, 1'b0);
        check("to_stb_hold", s_stb_o, 1'b1);
`endif
        @(posedge clk_i); #1;
        m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("to_after_err", m0_err_o, 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
        check("to_after_gnt", gnt_o, 2'b00);
`else
        check("to_after_gnt", gnt_o, 2'b01);
`endif
        @(negedge clk_i);
        check_quiet("to_end");

        check("sb_empty", 9'(exp_q.size()), 9'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
